// File: rtl/imem_load_arbiter.sv
// Purpose: owns the instruction ROM port and shares it between CPU fetch and a serial program loader.
// Latency: RUN passes cpu_addr to mem_addr combinationally; a word is written the cycle after its 4th byte.
// Backpressure: byte_ready is high only in WAIT/RECV, so bytes offered during WRITE/FINISH/RUN stay with the UART.
//
// Ports:
//   clock, reset      - system clock, synchronous active-high reset
//   load_req          - one-cycle pulse that starts a download (honoured in RUN only)
//   byte_valid/_data  - byte stream from the UART receiver; byte_ready accepts it
//   cpu_addr          - CPU fetch word address (PC[15:2])
//   mem_addr/_wdata/_we - prgrom port
//   cpu_hold          - ORed into the CPU reset while a load is in progress
//   load_busy         - high in any state other than RUN
//   load_done         - one-cycle pulse on the first RUN cycle after a load
//   word_count        - words written by the current or most recent load
module imem_load_arbiter #(
    parameter int ADDR_W      = 14,
    parameter int TIMEOUT     = 100000,
    parameter int HOLD_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_req,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              cpu_hold,
    output logic              load_busy,
    output logic              load_done,
    output logic [ADDR_W:0]   word_count
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [ADDR_W:0] WC_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_RUN,
        S_WAIT,
        S_RECV,
        S_WRITE,
        S_FINISH
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_wptr;
    logic [31:0]         r_word;
    logic [1:0]          r_bcnt;
    logic [IDLE_W-1:0]   r_idle;
    logic                r_final;
    logic [HOLD_W-1:0]   r_hold;
    logic                r_done;
    logic [ADDR_W:0]     r_wcount;

    logic                w_accept;
    logic                w_timeout;
    logic                w_ptr_last;
    logic [31:0]         w_padded;

    assign w_accept   = byte_valid & byte_ready;
    // The cycle that would take the idle count to TIMEOUT ends the load.
    assign w_timeout  = !w_accept && (r_idle == IDLE_W'(TIMEOUT - 1));
    assign w_ptr_last = &r_wptr;

    // Left-justify a partial word, zero-filling the missing low bytes.
    always_comb begin
        w_padded = r_word;
        case (r_bcnt)
            2'd1:    w_padded = {r_word[7:0], 24'h0};
            2'd2:    w_padded = {r_word[15:0], 16'h0};
            2'd3:    w_padded = {r_word[23:0], 8'h0};
            default: w_padded = r_word;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        byte_ready  = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = r_wptr;
        cpu_hold    = 1'b1;
        case (r_state)
            S_RUN: begin
                mem_addr = cpu_addr;
                cpu_hold = 1'b0;
                if (load_req) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                byte_ready = 1'b1;
                if (w_accept) begin
                    w_state_nxt = S_RECV;
                end
            end
            S_RECV: begin
                byte_ready = 1'b1;
                if (w_accept && (r_bcnt == 2'd3)) begin
                    w_state_nxt = S_WRITE;
                end else if (w_timeout) begin
                    w_state_nxt = (r_bcnt != 2'd0) ? S_WRITE : S_FINISH;
                end
            end
            S_WRITE: begin
                mem_we = 1'b1;
                // A full ROM ends the load exactly like a timeout does.
                w_state_nxt = (r_final || w_ptr_last) ? S_FINISH : S_RECV;
            end
            S_FINISH: begin
                if (r_hold == HOLD_W'(HOLD_CYCLES - 1)) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr   <= '0;
            r_word   <= '0;
            r_bcnt   <= '0;
            r_idle   <= '0;
            r_final  <= 1'b0;
            r_hold   <= '0;
            r_done   <= 1'b0;
            r_wcount <= '0;
        end else begin
            r_done <= (r_state == S_FINISH) && (w_state_nxt == S_RUN);
            r_hold <= '0;
            case (r_state)
                S_RUN: begin
                    if (load_req) begin
                        r_wptr   <= '0;
                        r_wcount <= '0;
                        r_bcnt   <= '0;
                        r_word   <= '0;
                        r_idle   <= '0;
                        r_final  <= 1'b0;
                    end
                end
                S_WAIT, S_RECV: begin
                    if (w_accept) begin
                        r_word <= {r_word[23:0], byte_data};
                        r_bcnt <= r_bcnt + 2'd1;
                        r_idle <= '0;
                    end else if (r_state == S_RECV) begin
                        r_idle <= r_idle + IDLE_W'(1);
                        if (w_timeout && (r_bcnt != 2'd0)) begin
                            r_word  <= w_padded;
                            r_final <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    r_wptr <= r_wptr + ADDR_W'(1);
                    if (r_wcount != WC_MAX) begin
                        r_wcount <= r_wcount + (ADDR_W + 1)'(1);
                    end
                    r_bcnt <= '0;
                    r_idle <= '0;
                end
                S_FINISH: begin
                    r_hold  <= r_hold + HOLD_W'(1);
                    r_final <= 1'b0;
                end
                default: begin
                    r_final <= 1'b0;
                end
            endcase
        end
    end

    assign mem_wdata  = r_word;
    assign load_busy  = (r_state != S_RUN);
    assign load_done  = r_done;
    assign word_count = r_wcount;

endmodule

// File: tb/tb_imem_load_arbiter.sv
module tb_imem_load_arbiter;

    localparam int TO = 20;
    localparam int HC = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        load_req;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [13:0] cpu_addr;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        cpu_hold;
    logic        load_busy;
    logic        load_done;
    logic [14:0] word_count;

    // Small-ROM instance for the memory-full case.
    logic        s_load_req;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic [2:0]  s_cpu_addr;
    logic [2:0]  s_addr;
    logic [31:0] s_wdata;
    logic        s_we;
    logic        s_hold;
    logic        s_busy;
    logic        s_done;
    logic [3:0]  s_wcount;

    imem_load_arbiter #(.ADDR_W(14), .TIMEOUT(TO), .HOLD_CYCLES(HC)) dut (
        .clock(clock), .reset(reset), .load_req(load_req),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .cpu_addr(cpu_addr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .cpu_hold(cpu_hold), .load_busy(load_busy),
        .load_done(load_done), .word_count(word_count)
    );

    imem_load_arbiter #(.ADDR_W(3), .TIMEOUT(TO), .HOLD_CYCLES(HC)) dut_s (
        .clock(clock), .reset(reset), .load_req(s_load_req),
        .byte_valid(s_valid), .byte_data(s_data), .byte_ready(s_ready),
        .cpu_addr(s_cpu_addr), .mem_addr(s_addr), .mem_wdata(s_wdata),
        .mem_we(s_we), .cpu_hold(s_hold), .load_busy(s_busy),
        .load_done(s_done), .word_count(s_wcount)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [13:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  tx_q[$];
    int          tests_run = 0;
    int          tests_failed = 0;
    int          cyc = 0;
    logic [31:0] m_word;
    int          m_cnt;
    logic [13:0] m_addr;
    bit          last_acc;
    bit          last_done;
    int          done_count = 0;
    int          done_cyc = 0;
    int          acc_count = 0;
    int          last_we_cyc = 0;
    logic [31:0] last_wdata = '0;

    // One clock cycle: observe outputs at the negedge (write scoreboard, byte
    // model), then return 1 time unit after the posedge for the next drive.
    task automatic step();
        wr_t e;
        last_acc  = 1'b0;
        last_done = 1'b0;
        @(negedge clock);
        if (load_done) begin
            last_done = 1'b1;
            done_count++;
            done_cyc = cyc;
        end
        if (mem_we) begin
            tests_run++;
            if (byte_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL ready_in_write: byte_ready=%b required 0", byte_ready);
            end
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_write: addr=%h data=%h", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data || (e.cyc >= 0 && cyc != e.cyc)) begin
                    tests_failed++;
                    $display("FAIL write: addr=%h data=%h cyc=%0d required addr=%h data=%h cyc=%0d",
                             mem_addr, mem_wdata, cyc, e.addr, e.data, e.cyc);
                end
            end
            last_we_cyc = cyc;
            last_wdata  = mem_wdata;
        end
        if (byte_valid && byte_ready && !reset) begin
            last_acc = 1'b1;
            acc_count++;
            m_word = {m_word[23:0], byte_data};
            m_cnt++;
            if (m_cnt == 4) begin
                exp_q.push_back('{m_addr, m_word, cyc + 1});
                m_addr++;
                m_cnt = 0;
            end
        end
        @(posedge clock);
        cyc++;
        #1;
    endtask

    task automatic send_seq();
        bit got;
        while (tx_q.size() > 0) begin
            byte_data  = tx_q.pop_front();
            byte_valid = 1'b1;
            got = 1'b0;
            for (int k = 0; k < 50 && !got; k++) begin
                step();
                got = last_acc;
            end
            tests_run++;
            if (!got) begin
                tests_failed++;
                $display("FAIL byte_accept: byte %h not accepted within 50 cycles", byte_data);
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic start_load();
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        m_addr = '0;
        m_cnt  = 0;
        m_word = '0;
        tests_run++;
        if ({cpu_hold, load_busy, byte_ready} !== 3'b111) begin
            tests_failed++;
            $display("FAIL enter_wait: hold/busy/ready=%b required 111", {cpu_hold, load_busy, byte_ready});
        end
    endtask

    task automatic wait_done(input int budget, input logic [14:0] exp_wc);
        bit got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            step();
            got = last_done;
        end
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("FAIL done_timeout: load_done not seen within %0d cycles", budget);
        end
        tests_run++;
        if ({load_done, cpu_hold, load_busy} !== 3'b000) begin
            tests_failed++;
            $display("FAIL after_done: done/hold/busy=%b required 000", {load_done, cpu_hold, load_busy});
        end
        tests_run++;
        if (word_count !== exp_wc) begin
            tests_failed++;
            $display("FAIL word_count: got %0d required %0d", word_count, exp_wc);
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL missing_write: %0d expected writes never seen", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        tests_run++;
        if ({byte_ready, mem_we, cpu_hold, load_busy, load_done} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: ready/we/hold/busy/done=%b required 00000",
                     {byte_ready, mem_we, cpu_hold, load_busy, load_done});
        end
        tests_run++;
        if (mem_wdata !== 32'h0 || word_count !== 15'd0) begin
            tests_failed++;
            $display("FAIL reset_data: wdata=%h wc=%0d required 0/0", mem_wdata, word_count);
        end
        tests_run++;
        if ({s_ready, s_we, s_hold, s_busy, s_done} !== 5'b0 || s_wcount !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_small: ctrl=%b wc=%0d required 0/0",
                     {s_ready, s_we, s_hold, s_busy, s_done}, s_wcount);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_run_passthrough();
        logic [13:0] exp_a;
        for (int i = 0; i < 4; i++) begin
            exp_a = (i < 2) ? 14'h0005 : 14'h1234;
            cpu_addr   = (i < 2) ? 14'h0005 : 14'h1234;
            byte_valid = i[0];
            byte_data  = 8'hEE;
            #1;
            tests_run++;
            if (mem_addr !== exp_a || {mem_we, byte_ready, cpu_hold} !== 3'b000) begin
                tests_failed++;
                $display("FAIL run_pass: addr=%h we/ready/hold=%b required addr=%h 000",
                         mem_addr, {mem_we, byte_ready, cpu_hold}, exp_a);
            end
            step();
        end
        byte_valid = 1'b0;
        cpu_addr   = 14'h0;
    endtask

    task automatic test_two_word();
        start_load();
        tx_q = '{8'h3C, 8'h01, 8'h00, 8'h10, 8'h24, 8'h21, 8'h00, 8'h04};
        send_seq();
        wait_done(TO + 20, 15'd2);
        tests_run++;
        if (last_wdata !== 32'h24210004) begin
            tests_failed++;
            $display("FAIL two_word_last: got %h required 24210004", last_wdata);
        end
    endtask

    task automatic test_partial_flush();
        start_load();
        tx_q = '{8'hAA, 8'hBB};
        send_seq();
        exp_q.push_back('{14'h0, 32'hAABB0000, -1});
        wait_done(TO + 20, 15'd1);
        tests_run++;
        if (done_cyc - last_we_cyc != HC + 1) begin
            tests_failed++;
            $display("FAIL finish_len: write-to-done %0d cycles required %0d", done_cyc - last_we_cyc, HC + 1);
        end
    endtask

    task automatic test_backpressure();
        int acc0 = acc_count;
        start_load();
        tx_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send_seq();
        tests_run++;
        if (acc_count - acc0 != 8) begin
            tests_failed++;
            $display("FAIL bp_bytes: accepted %0d required 8", acc_count - acc0);
        end
        wait_done(TO + 20, 15'd2);
        tests_run++;
        if (last_wdata !== 32'h55667788) begin
            tests_failed++;
            $display("FAIL bp_last: got %h required 55667788", last_wdata);
        end
    endtask

    task automatic test_full_memory();
        int nacc = 0;
        int nwr  = 0;
        bit got_done = 1'b0;
        bit accepted;
        logic [31:0] exp_w;
        s_load_req = 1'b1;
        @(posedge clock); #1;
        s_load_req = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h00;
        for (int k = 0; k < 300 && !got_done; k++) begin
            @(negedge clock);
            if (s_done) got_done = 1'b1;
            if (s_we) begin
                exp_w = {8'(4 * nwr), 8'(4 * nwr + 1), 8'(4 * nwr + 2), 8'(4 * nwr + 3)};
                tests_run++;
                if (s_addr !== 3'(nwr) || s_wdata !== exp_w) begin
                    tests_failed++;
                    $display("FAIL full_write: addr=%h data=%h required addr=%h data=%h",
                             s_addr, s_wdata, 3'(nwr), exp_w);
                end
                nwr++;
            end
            accepted = s_valid && s_ready;
            @(posedge clock); #1;
            if (accepted) begin
                nacc++;
                if (nacc < 40) s_data = 8'(nacc);
                else s_valid = 1'b0;
            end
        end
        tests_run++;
        if (!got_done || nacc != 32 || nwr != 8) begin
            tests_failed++;
            $display("FAIL full_mem: done=%b bytes=%0d writes=%0d required 1/32/8", got_done, nacc, nwr);
        end
        tests_run++;
        if (s_wcount !== 4'd8 || s_hold !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_wc: wc=%0d hold=%b required 8/0", s_wcount, s_hold);
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reset_midload();
        int d0;
        start_load();
        tx_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_seq();
        tests_run++;
        if (word_count !== 15'd1) begin
            tests_failed++;
            $display("FAIL midload_wc: got %0d required 1", word_count);
        end
        d0 = done_count;
        reset = 1'b1;
        step();
        tests_run++;
        if ({load_busy, cpu_hold, mem_we} !== 3'b000 || word_count !== 15'd0) begin
            tests_failed++;
            $display("FAIL midload_reset: busy/hold/we=%b wc=%0d required 000/0",
                     {load_busy, cpu_hold, mem_we}, word_count);
        end
        reset = 1'b0;
        m_cnt = 0;
        for (int k = 0; k < 10; k++) step();
        tests_run++;
        if (done_count != d0 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL midload_done: done pulses=%0d pending=%0d required 0/0", done_count - d0, exp_q.size());
        end
    endtask

    initial begin
        reset      = 1'b1;
        load_req   = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        cpu_addr   = 14'h0;
        s_load_req = 1'b0;
        s_valid    = 1'b0;
        s_data     = 8'h00;
        s_cpu_addr = 3'h0;
        m_word = '0;
        m_cnt  = 0;
        m_addr = '0;
        test_reset();
        test_run_passthrough();
        test_two_word();
        test_partial_flush();
        test_backpressure();
        test_full_memory();
        test_reset_midload();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/imem_load_arbiter.md
Name: imem_load_arbiter

Overview:
- Owns the single port of the instruction ROM (prgrom, 14-bit word address, 32-bit data) and shares it between two requesters:
  - the CPU fetch path (PC[15:2]);
  - a serial program loader that streams bytes in from the UART receiver.
- During a load it holds the CPU in reset, assembles bytes into words and writes them sequentially from address 0.
- When the load ends it releases the CPU, which then fetches from PC=0.

Parameters:
- ADDR_W, 14, ROM word-address width; depth = 2**ADDR_W.
- TIMEOUT, 100000, consecutive idle cycles (no accepted byte) that end a load.
- HOLD_CYCLES, 2, cycles cpu_hold stays high after the final write.

Ports:
- clock  input  1  system clock; all state on posedge.
- reset  input  1  synchronous, active-high.
- load_req  input  1  one-cycle pulse requesting a program download.
- byte_valid  input  1  UART receiver has a byte.
- byte_data  input  8  received byte.
- byte_ready  output  1  loader accepts byte this cycle.
- cpu_addr  input  ADDR_W  fetch word address from the CPU (PC[15:2]).
- mem_addr  output  ADDR_W  address to prgrom.
- mem_wdata  output  32  write data to prgrom.
- mem_we  output  1  prgrom write enable.
- cpu_hold  output  1  ORed into the CPU reset; high while loading.
- load_busy  output  1  high in any state other than RUN.
- load_done  output  1  one-cycle pulse on return to RUN after a load.
- word_count  output  ADDR_W+1  words written by the last or current load.

Behaviour:
- Reset values:
  - state = RUN.
  - byte_ready = 0, mem_we = 0, mem_wdata = 0.
  - cpu_hold = 0, load_busy = 0, load_done = 0.
  - word_count = 0, write pointer = 0, byte counter = 0, idle counter = 0.
- Reset mid-load abandons the load immediately. Words already written stay in the ROM.
- RUN:
  - mem_addr = cpu_addr combinationally; mem_we = 0; byte_ready = 0.
  - load_req = 1 -> next state WAIT; clear write pointer, word_count, byte counter and shift register.
  - load_req is ignored in every other state.
- WAIT:
  - cpu_hold = 1, byte_ready = 1. There is no timeout; the block waits indefinitely for the first byte.
  - An accepted byte (byte_valid & byte_ready) -> RECV.
- RECV:
  - byte_ready = 1.
  - Each accepted byte shifts in big-endian: word = {word[23:0], byte_data}. The byte counter increments mod 4.
  - The idle counter clears on accept and increments otherwise.
  - 4th byte of a word accepted in cycle N -> WRITE in cycle N+1.
  - Idle counter reaches TIMEOUT:
    - byte counter != 0 -> pad the word: left-shift by 8×(4−count), fill low bytes with 0x00, then go to WRITE with the final flag set;
    - byte counter == 0 -> go to FINISH.
- WRITE (exactly 1 cycle):
  - byte_ready = 0, mem_we = 1, mem_addr = write pointer, mem_wdata = assembled word.
  - At end of cycle: write pointer +1, word_count +1, byte counter = 0.
  - Next state:
    - FINISH if the final flag is set, or the pointer was 2**ADDR_W−1 (memory full; later bytes are never accepted);
    - otherwise RECV with the idle counter cleared.
- FINISH:
  - cpu_hold = 1, byte_ready = 0, mem_we = 0.
  - Counts HOLD_CYCLES cycles, then RUN. load_done = 1 in the first RUN cycle only.
- Outside RUN, mem_addr = write pointer and cpu_hold = 1. cpu_addr is ignored.
- The CPU never sees a partially written program, because cpu_hold is high from the cycle after load_req through the end of FINISH.
- byte_valid while byte_ready = 0 is not consumed. The UART side must hold the byte.
- word_count saturates at 2**ADDR_W.

Test Plan:
- RUN passthrough: cpu_addr = 0x0005, then 0x1234, with byte_valid toggling -> mem_addr follows in the same cycle; mem_we = 0, byte_ready = 0, cpu_hold = 0 throughout.
- Two-word load:
  - Stimulus: load_req, then bytes 3C 01 00 10 24 21 00 04 back-to-back, then idle for TIMEOUT.
  - Required: writes 0x3C010010 at addr 0 and 0x24210004 at addr 1, each a single mem_we cycle one cycle after the 4th byte.
  - Then FINISH for HOLD_CYCLES, load_done pulse, word_count = 2.
- Partial-word flush: load_req, bytes AA BB, then idle TIMEOUT cycles -> one write of 0xAABB0000 at addr 0; word_count = 1; returns to RUN.
- Backpressure in WRITE: byte_valid held high continuously with 8 bytes -> byte_ready low during each WRITE cycle. No byte lost or duplicated; addresses 0 and 1 are correct.
- Full memory (ADDR_W = 3 build): stream 40 bytes -> exactly 8 writes (addr 0..7), then FINISH. Remaining bytes are never accepted; word_count = 8.
- Reset mid-load: assert reset after 5 bytes -> next cycle state = RUN; cpu_hold = 0, mem_we = 0, word_count = 0. Word 0 stays written; no load_done pulse.
